// File: rtl/montgomery_const_gen_if.sv
// rtl/montgomery_const_gen_if.sv - request/result bundle for the Montgomery constant generator
interface montgomery_const_gen_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int KW = $clog2(DATA_WIDTH + 1);

    logic                  start;
    logic [DATA_WIDTH-1:0] modulus;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [KW-1:0]         r_log2;
    logic [DATA_WIDTH-1:0] r_mod;
    logic [DATA_WIDTH-1:0] r2_mod;
    logic [DATA_WIDTH-1:0] n_prime;

    // Requester side: issues a modulus, observes status and constants.
    modport master (
        output start,
        output modulus,
        input  busy,
        input  done,
        input  err,
        input  r_log2,
        input  r_mod,
        input  r2_mod,
        input  n_prime
    );

    // Generator side.
    modport slave (
        input  start,
        input  modulus,
        output busy,
        output done,
        output err,
        output r_log2,
        output r_mod,
        output r2_mod,
        output n_prime
    );
endinterface

// File: rtl/montgomery_const_gen.sv
// rtl/montgomery_const_gen.sv - sequential R mod N, R^2 mod N and N' generator (MONT_NPRIME_EN enables N')
module montgomery_const_gen #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    montgomery_const_gen_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int KW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SQUARE,
        S_NPRIME,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [DW-1:0]   n_q;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   i_q;
    logic [DW:0]     x_q;

    logic            done_q;
    logic            err_q;
    logic [KW-1:0]   r_log2_q;
    logic [DW-1:0]   r_mod_q;
    logic [DW-1:0]   r2_mod_q;

    logic [KW-1:0]   k_d;
    logic [DW:0]     pow2_d;
    logic [DW:0]     rmod_d;
    logic [DW:0]     x_dbl;
    logic [DW:0]     x_sq_d;
    logic            bad_mod;

`ifdef MONT_NPRIME_EN
    logic [DW:0]     t_q;
    logic [DW-1:0]   u_q;
    logic [DW-1:0]   n_prime_q;
    logic [DW-1:0]   mask_d;
    logic [DW:0]     t_sum;
    logic [DW:0]     t_d;
    logic [DW-1:0]   u_d;
`endif

    // Bit length of N, 2^K and R mod N = 2^K - N (valid because N < 2^K <= 2N).
    always_comb begin
        k_d    = '0;
        pow2_d = '0;
        for (int b = 0; b < DW; b++) begin
            if (n_q[b]) begin
                k_d = KW'(b + 1);
            end
        end
        for (int b = 0; b <= DW; b++) begin
            if (k_d == KW'(b)) begin
                pow2_d[b] = 1'b1;
            end
        end
        rmod_d  = pow2_d - {1'b0, n_q};
        bad_mod = !n_q[0] || (n_q < DW'(3));
    end

    // One modular doubling step: x < N keeps 2x within DW+1 bits, one subtract suffices.
    always_comb begin
        x_dbl  = x_q << 1;
        x_sq_d = x_dbl;
        if (x_dbl >= {1'b0, n_q}) begin
            x_sq_d = x_dbl - {1'b0, n_q};
        end
    end

`ifdef MONT_NPRIME_EN
    // Bitwise Hensel lifting of -N^-1: each step clears bit 0 of t by adding N when it is odd.
    always_comb begin
        mask_d = '0;
        for (int b = 0; b < DW; b++) begin
            if (i_q == KW'(b)) begin
                mask_d[b] = 1'b1;
            end
        end
        t_sum = t_q;
        u_d   = u_q;
        if (t_q[0]) begin
            t_sum = t_q + {1'b0, n_q};
            u_d   = u_q | mask_d;
        end
        t_d = t_sum >> 1;
    end
`endif

    // Control FSM with registered results; done pulses in the cycle the results appear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            k_q      <= '0;
            i_q      <= '0;
            x_q      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            r_log2_q <= '0;
            r_mod_q  <= '0;
            r2_mod_q <= '0;
`ifdef MONT_NPRIME_EN
            t_q       <= '0;
            u_q       <= '0;
            n_prime_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        n_q     <= bus.modulus;
                        i_q     <= '0;
                        state_q <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    k_q <= k_d;
                    x_q <= rmod_d;
                    i_q <= '0;
`ifdef MONT_NPRIME_EN
                    t_q <= {{DW{1'b0}}, 1'b1};
                    u_q <= '0;
`endif
                    if (bad_mod) begin
                        // Rejected modulus: flag the error and zero every constant.
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        r_log2_q <= '0;
                        r_mod_q  <= '0;
                        r2_mod_q <= '0;
`ifdef MONT_NPRIME_EN
                        n_prime_q <= '0;
`endif
                    end else begin
                        state_q <= S_SQUARE;
                    end
                end

                S_SQUARE: begin
                    x_q <= x_sq_d;
                    if (i_q == k_q - KW'(1)) begin
                        i_q <= '0;
`ifdef MONT_NPRIME_EN
                        state_q <= S_NPRIME;
`else
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        err_q    <= 1'b0;
                        r_log2_q <= k_q;
                        r_mod_q  <= rmod_d[DW-1:0];
                        r2_mod_q <= x_sq_d[DW-1:0];
`endif
                    end else begin
                        i_q <= i_q + KW'(1);
                    end
                end

`ifdef MONT_NPRIME_EN
                S_NPRIME: begin
                    t_q <= t_d;
                    u_q <= u_d;
                    if (i_q == k_q - KW'(1)) begin
                        i_q       <= '0;
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        err_q     <= 1'b0;
                        r_log2_q  <= k_q;
                        r_mod_q   <= rmod_d[DW-1:0];
                        r2_mod_q  <= x_q[DW-1:0];
                        n_prime_q <= u_d;
                    end else begin
                        i_q <= i_q + KW'(1);
                    end
                end
`endif

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.r_log2  = r_log2_q;
    assign bus.r_mod   = r_mod_q;
    assign bus.r2_mod  = r2_mod_q;
`ifdef MONT_NPRIME_EN
    assign bus.n_prime = n_prime_q;
`else
    assign bus.n_prime = '0;
`endif
endmodule

// File: tb/tb_montgomery_const_gen.sv
// tb/tb_montgomery_const_gen.sv - scoreboard bench for montgomery_const_gen at widths 8 and 16
`timescale 1ns/1ps
module tb_montgomery_const_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    typedef struct {
        longint n;
        bit     err;
        longint k;
        longint rmod;
        longint r2;
        longint np;
        longint lat;
        longint acc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];

    montgomery_const_gen_if #(.DATA_WIDTH(8))  b8 ();
    montgomery_const_gen_if #(.DATA_WIDTH(16)) b16 ();

    montgomery_const_gen #(.DATA_WIDTH(8)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    montgomery_const_gen #(.DATA_WIDTH(16)) u16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    // Reference: direct arithmetic on R = 2^K; N' from Newton inversion modulo R.
    function automatic exp_t model(input longint n, input longint acc);
        exp_t   e;
        longint r;
        longint inv;
        longint ee;
        e.n = n; e.acc = acc; e.err = 1'b0; e.k = 0;
        e.rmod = 0; e.r2 = 0; e.np = 0; e.lat = 2;
        if ((n % 2) == 0 || n < 3) begin
            e.err = 1'b1;
            return e;
        end
        while ((longint'(1) << e.k) <= n) e.k++;
        r      = longint'(1) << e.k;
        e.rmod = r % n;
        e.r2   = (r * r) % n;
        inv    = n;
        for (int j = 0; j < 6; j++) begin
            ee  = (inv * n) % r;
            inv = (inv * ((2 + r - ee) % r)) % r;
        end
`ifdef MONT_NPRIME_EN
        e.np  = (r - inv) % r;
        e.lat = 2 * e.k + 2;
`else
        e.np  = 0;
        e.lat = e.k + 2;
`endif
        return e;
    endfunction

    task automatic score(input string tag, input exp_t e, input longint err, input longint k,
                         input longint rmod, input longint r2, input longint np);
        check({tag, "_err"},     err,     longint'(e.err));
        check({tag, "_r_log2"},  k,       e.k);
        check({tag, "_r_mod"},   rmod,    e.rmod);
        check({tag, "_r2_mod"},  r2,      e.r2);
        check({tag, "_n_prime"}, np,      e.np);
        check({tag, "_latency"}, longint'(cyc) - e.acc, e.lat);
`ifdef MONT_NPRIME_EN
        if (!e.err) check({tag, "_nprime_identity"}, (e.n * np + 1) % (longint'(1) << e.k), 0);
`endif
    endtask

    // Monitors: pop the oldest expectation whenever an instance reports done.
    always @(negedge clk) begin
        if (rst_n && b8.done) begin
            check("m8_done_with_busy", longint'(b8.busy), 1);
            check("m8_run_outstanding", longint'(q8.size() > 0), 1);
            if (q8.size() > 0)
                score("m8", q8.pop_front(), longint'(b8.err), longint'(b8.r_log2),
                      longint'(b8.r_mod), longint'(b8.r2_mod), longint'(b8.n_prime));
        end
    end

    always @(negedge clk) begin
        if (rst_n && b16.done) begin
            check("m16_done_with_busy", longint'(b16.busy), 1);
            check("m16_run_outstanding", longint'(q16.size() > 0), 1);
            if (q16.size() > 0)
                score("m16", q16.pop_front(), longint'(b16.err), longint'(b16.r_log2),
                      longint'(b16.r_mod), longint'(b16.r2_mod), longint'(b16.n_prime));
        end
    end

    task automatic issue(input int w, input longint n, input bit hold);
        int guard = 0;
        @(negedge clk);
        while (((w == 8) ? b8.busy : b16.busy) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("issue_idle_wait_bounded", longint'(guard < 300), 1);
        if (w == 8) begin
            b8.modulus = n[7:0];
            b8.start   = 1'b1;
            q8.push_back(model(n, longint'(cyc)));
        end else begin
            b16.modulus = n[15:0];
            b16.start   = 1'b1;
            q16.push_back(model(n, longint'(cyc)));
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            if (w == 8) b8.start = 1'b0;
            else b16.start = 1'b0;
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((q8.size() > 0 || q16.size() > 0 || b8.busy || b16.busy) && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("drain_bounded", longint'(g < 500), 1);
    endtask

    task automatic check_zero8(input string tag);
        check({tag, "_busy"},    longint'(b8.busy),    0);
        check({tag, "_done"},    longint'(b8.done),    0);
        check({tag, "_err"},     longint'(b8.err),     0);
        check({tag, "_r_log2"},  longint'(b8.r_log2),  0);
        check({tag, "_r_mod"},   longint'(b8.r_mod),   0);
        check({tag, "_r2_mod"},  longint'(b8.r2_mod),  0);
        check({tag, "_n_prime"}, longint'(b8.n_prime), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     cnt;
        int     g;
        exp_t   e13;
        longint n;

        b8.start = 1'b0;  b8.modulus = '0;
        b16.start = 1'b0; b16.modulus = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero8("reset8");
        check("reset16_busy",   longint'(b16.busy),   0);
        check("reset16_r_mod",  longint'(b16.r_mod),  0);
        check("reset16_r2_mod", longint'(b16.r2_mod), 0);
        rst_n = 1'b1;

        // N = 13: results via the scoreboard, busy span counted here.
        e13 = model(13, 0);
        issue(8, 13, 1'b0);
        cnt = 0; g = 0;
        @(negedge clk);
        while (b8.busy && g < 100) begin
            cnt++; g++;
            @(negedge clk);
        end
        check("busy_cycles_n13", longint'(cnt), e13.lat);

        issue(8, 255, 1'b0);
        issue(8, 12, 1'b0);
        issue(8, 1, 1'b0);

        // start held high across consecutive runs.
        issue(8, 13, 1'b1);
        issue(8, 77, 1'b1);
        issue(8, 201, 1'b0);

        // Start pulse and modulus change while a run is in flight.
        issue(8, 13, 1'b0);
        repeat (2) @(negedge clk);
        b8.start = 1'b1; b8.modulus = 8'd99;
        @(negedge clk);
        b8.start = 1'b0; b8.modulus = 8'd3;
        drain();

        // Reset in cycle 5 of a run: abandoned, no done, everything zero.
        @(negedge clk);
        b8.modulus = 8'd13; b8.start = 1'b1;
        @(posedge clk);
        #1 b8.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_zero8("midrun_reset");
        repeat (30) @(negedge clk);
        check("after_reset_idle_busy", longint'(b8.busy), 0);
        check("after_reset_r_log2", longint'(b8.r_log2), 0);

        // Reset coinciding with start: reset wins.
        @(negedge clk);
        rst_n = 1'b0; b8.modulus = 8'd13; b8.start = 1'b1;
        @(posedge clk);
        #1 b8.start = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        check("reset_beats_start_busy", longint'(b8.busy), 0);

        fork
            begin
                for (int j = 0; j < 500; j++) begin
                    n = longint'($urandom_range(1, 127)) * 2 + 1;
                    issue(8, n, 1'b0);
                end
            end
            begin
                for (int j = 0; j < 500; j++) begin
                    longint m;
                    m = longint'($urandom_range(1, 32767)) * 2 + 1;
                    issue(16, m, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
                end
                #1 b16.start = 1'b0;
            end
        join
        drain();
        check("q8_empty_at_end",  longint'(q8.size()),  0);
        check("q16_empty_at_end", longint'(q16.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
